demux_sched_1x4: RTL and testbench

Sequencing controller that sits in front of the 1x4 demultiplexer and shares a single input stream among four consumers. It accepts words over a valid/ready handshake, holds each word in a one-entry register, and presents it to exactly one output, chosen either by an explicit destination field or by a round-robin pointer. A per-word watchdog drops words a consumer never takes, and per-output delivery counters support debug and verification.

---
 rtl/demux_sched_1x4_pkg.sv | 24 ++
 rtl/demux_sched_1x4_if.sv | 36 +++
 rtl/demux_sched_1x4_sat_counter.sv | 19 +
 rtl/demux_sched_1x4.sv | 115 +++++++++++
 tb/tb_demux_sched_1x4.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/demux_sched_1x4_pkg.sv
// Shared definitions for the 1x4 demultiplexer sequencing controller:
// output count, FSM state type, mode encodings and a one-hot helper.
package demux_sched_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE,
        HOLD
    } sched_state_t;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    // Expands a destination index into the one-hot out_valid pattern.
    function automatic logic [NUM_OUT-1:0] dest_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_OUT-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/demux_sched_1x4_if.sv
// Handshake bundle between the producer, the controller and the four consumers.
// master = the environment side, slave = the controller.
interface demux_sched_1x4_if #(
    parameter int W = 8
);
    import demux_sched_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_data;
    logic [SEL_W-1:0]     in_dest;
    logic [NUM_OUT-1:0]   out_valid;
    logic [NUM_OUT-1:0]   out_ready;
    logic [W-1:0]         out_data;

    modport master (
        output in_valid,
        output in_data,
        output in_dest,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_dest,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/demux_sched_1x4_sat_counter.sv
// Event counter with increment enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/demux_sched_1x4.sv
// One-entry holding stage that steers each input word to one of four consumers,
// by explicit destination or round-robin, with a per-word drop watchdog.
module demux_sched_1x4
    import demux_sched_pkg::*;
#(
    parameter int W       = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    demux_sched_1x4_if.slave bus,
    output logic             drop,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic [CNT_W-1:0] drop_cnt
);

    // age only has to reach TIMEOUT-1; a zero TIMEOUT turns the watchdog off
    localparam int AGE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(WD_EN ? TIMEOUT - 1 : 0);

    sched_state_t       state;
    sched_state_t       state_next;
    logic [SEL_W-1:0]   tgt;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   sel_tgt;
    logic [AGE_W-1:0]   age;
    logic [W-1:0]       data_q;
    logic [NUM_OUT-1:0] valid_q;
    logic [NUM_OUT-1:0] deliver_vec;
    logic               deliver;
    logic               timeout;
    logic               in_ready;
    logic               accept;

    always_comb begin
        deliver    = 1'b0;
        timeout    = 1'b0;
        in_ready   = 1'b0;
        accept     = 1'b0;
        state_next = state;

        deliver  = (state == HOLD) && bus.out_ready[tgt];
        timeout  = WD_EN && (state == HOLD) && !deliver && (age == AGE_LAST);
        in_ready = (state == IDLE) || deliver;
        accept   = bus.in_valid && in_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_next = HOLD;
                end else if (deliver || timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign sel_tgt = (mode == MODE_RR) ? rr_ptr : bus.in_dest;

    // A new accept overrides release, so deliver+accept keeps the stage full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt     <= '0;
            rr_ptr  <= '0;
            age     <= '0;
            data_q  <= '0;
            valid_q <= '0;
        end else if (accept) begin
            tgt     <= sel_tgt;
            data_q  <= bus.in_data;
            valid_q <= dest_onehot(sel_tgt);
            age     <= '0;
            if (mode == MODE_RR) begin
                rr_ptr <= rr_ptr + 2'd1;
            end
        end else if (deliver || timeout) begin
            valid_q <= '0;
        end else if (state == HOLD) begin
            age <= age + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign drop          = timeout;
    assign deliver_vec   = deliver ? dest_onehot(tgt) : '0;

    sat_counter #(.WIDTH(CNT_W)) u_cnt0 (.clk(clk), .rst(rst), .inc(deliver_vec[0]), .count(cnt0));
    sat_counter #(.WIDTH(CNT_W)) u_cnt1 (.clk(clk), .rst(rst), .inc(deliver_vec[1]), .count(cnt1));
    sat_counter #(.WIDTH(CNT_W)) u_cnt2 (.clk(clk), .rst(rst), .inc(deliver_vec[2]), .count(cnt2));
    sat_counter #(.WIDTH(CNT_W)) u_cnt3 (.clk(clk), .rst(rst), .inc(deliver_vec[3]), .count(cnt3));
    sat_counter #(.WIDTH(CNT_W)) u_drop (.clk(clk), .rst(rst), .inc(timeout), .count(drop_cnt));

endmodule

// File: tb/tb_demux_sched_1x4.sv
// Drives two controllers (wide and 2-bit counters, watchdog of 4) with identical
// stimulus and compares both against a word-level reference model.
module tb_demux_sched_1x4;
    import demux_sched_pkg::*;

    localparam int W     = 8;
    localparam int TMO   = 4;
    localparam int CNT_A = 16;
    localparam int CNT_B = 2;
    localparam int SAT_B = (1 << CNT_B) - 1;

    logic clk = 1'b0;
    logic rst;
    logic mode;

    demux_sched_1x4_if #(.W(W)) bus_a ();
    demux_sched_1x4_if #(.W(W)) bus_b ();

    logic             drop_a;
    logic             drop_b;
    logic [CNT_A-1:0] cnt_a [NUM_OUT];
    logic [CNT_B-1:0] cnt_b [NUM_OUT];
    logic [CNT_A-1:0] drop_cnt_a;
    logic [CNT_B-1:0] drop_cnt_b;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: the held word, who it is for, and how long it has been offered
    bit   m_held;
    int   m_data;
    int   m_tgt;
    int   m_rr;
    int   m_offered;
    int   m_cnt [NUM_OUT];
    int   m_drops;

    demux_sched_1x4 #(.W(W), .CNT_W(CNT_A), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .bus(bus_a.slave), .drop(drop_a),
        .cnt0(cnt_a[0]), .cnt1(cnt_a[1]), .cnt2(cnt_a[2]), .cnt3(cnt_a[3]),
        .drop_cnt(drop_cnt_a)
    );

    demux_sched_1x4 #(.W(W), .CNT_W(CNT_B), .TIMEOUT(TMO)) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .bus(bus_b.slave), .drop(drop_b),
        .cnt0(cnt_b[0]), .cnt1(cnt_b[1]), .cnt2(cnt_b[2]), .cnt3(cnt_b[3]),
        .drop_cnt(drop_cnt_b)
    );

    always #5 clk = ~clk;

    function automatic int satB(input int x);
        return (x > SAT_B) ? SAT_B : x;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_held    = 1'b0;
        m_data    = 0;
        m_tgt     = 0;
        m_rr      = 0;
        m_offered = 0;
        m_drops   = 0;
        for (int k = 0; k < NUM_OUT; k++) m_cnt[k] = 0;
    endtask

    // Called at posedge+1; checks the cycle's outputs, then advances one edge.
    task automatic applyStimulus(input logic md, input logic v, input logic [7:0] d,
                                 input logic [1:0] dest, input logic [3:0] rdy);
        bit         exp_deliver;
        bit         exp_timeout;
        bit         exp_ready;
        logic [3:0] exp_valid;
        mode            = md;
        bus_a.in_valid  = v;
        bus_a.in_data   = d;
        bus_a.in_dest   = dest;
        bus_a.out_ready = rdy;
        bus_b.in_valid  = v;
        bus_b.in_data   = d;
        bus_b.in_dest   = dest;
        bus_b.out_ready = rdy;
        #1;
        exp_deliver = m_held && rdy[m_tgt];
        exp_timeout = m_held && !exp_deliver && (m_offered == TMO);
        exp_ready   = !m_held || exp_deliver;
        exp_valid   = m_held ? (4'b0001 << m_tgt) : 4'b0000;

        checkOutput("in_ready_a", 32'(bus_a.in_ready), 32'(exp_ready));
        checkOutput("in_ready_b", 32'(bus_b.in_ready), 32'(exp_ready));
        checkOutput("drop_a", 32'(drop_a), 32'(exp_timeout));
        checkOutput("drop_b", 32'(drop_b), 32'(exp_timeout));
        checkOutput("out_valid_a", 32'(bus_a.out_valid), 32'(exp_valid));
        checkOutput("out_valid_b", 32'(bus_b.out_valid), 32'(exp_valid));
        checkOutput("out_data_a", 32'(bus_a.out_data), 32'(m_data));
        checkOutput("out_data_b", 32'(bus_b.out_data), 32'(m_data));
        for (int k = 0; k < NUM_OUT; k++) begin
            checkOutput($sformatf("cnt%0d_a", k), 32'(cnt_a[k]), 32'(m_cnt[k]));
            checkOutput($sformatf("cnt%0d_b", k), 32'(cnt_b[k]), 32'(satB(m_cnt[k])));
        end
        checkOutput("drop_cnt_a", 32'(drop_cnt_a), 32'(m_drops));
        checkOutput("drop_cnt_b", 32'(drop_cnt_b), 32'(satB(m_drops)));

        @(posedge clk);
        if (exp_deliver) m_cnt[m_tgt]++;
        if (exp_timeout) m_drops++;
        if (v && exp_ready) begin
            m_held    = 1'b1;
            m_data    = int'(d);
            m_tgt     = md ? m_rr : int'(dest);
            m_rr      = md ? (m_rr + 1) % NUM_OUT : m_rr;
            m_offered = 1;
        end else if (exp_deliver || exp_timeout) begin
            m_held = 1'b0;
        end else if (m_held) begin
            m_offered++;
        end
        #1;
    endtask

    // Asserts reset between edges, checks the asynchronous clear, then releases it.
    task automatic resetDut();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid_a", 32'(bus_a.out_valid), 32'h0);
        checkOutput("rst_out_data_a", 32'(bus_a.out_data), 32'h0);
        checkOutput("rst_drop_a", 32'(drop_a), 32'h0);
        checkOutput("rst_in_ready_a", 32'(bus_a.in_ready), 32'h1);
        checkOutput("rst_cnt1_a", 32'(cnt_a[1]), 32'h0);
        checkOutput("rst_drop_cnt_a", 32'(drop_cnt_a), 32'h0);
        checkOutput("rst_out_valid_b", 32'(bus_b.out_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        logic       md;
        logic [3:0] rdy_mask;
        rst  = 1'b1;
        mode = MODE_ADDR;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_dest = '0; bus_a.out_ready = '0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_dest = '0; bus_b.out_ready = '0;
        modelReset();
        @(posedge clk);
        #1;
        resetDut();

        // Addressed mode at full rate: targets 3,2,1,0
        applyStimulus(MODE_ADDR, 1'b1, 8'h11, 2'd3, 4'b1111);
        applyStimulus(MODE_ADDR, 1'b1, 8'h22, 2'd2, 4'b1111);
        applyStimulus(MODE_ADDR, 1'b1, 8'h33, 2'd1, 4'b1111);
        applyStimulus(MODE_ADDR, 1'b1, 8'h44, 2'd0, 4'b1111);
        applyStimulus(MODE_ADDR, 1'b0, 8'h00, 2'd0, 4'b1111);
        for (int k = 0; k < NUM_OUT; k++)
            checkOutput($sformatf("addr_cnt%0d", k), 32'(cnt_a[k]), 32'd1);

        // Reset while a word is held
        applyStimulus(MODE_ADDR, 1'b1, 8'h99, 2'd2, 4'b0000);
        resetDut();

        // Round-robin ignores in_dest: targets 0,1,2,3,0,1
        for (int i = 0; i < 6; i++)
            applyStimulus(MODE_RR, 1'b1, 8'(8'hA0 + i), 2'd0, 4'b1111);
        applyStimulus(MODE_RR, 1'b0, 8'h00, 2'd0, 4'b1111);
        checkOutput("rr_cnt0", 32'(cnt_a[0]), 32'd2);
        checkOutput("rr_cnt1", 32'(cnt_a[1]), 32'd2);
        checkOutput("rr_cnt2", 32'(cnt_a[2]), 32'd1);
        checkOutput("rr_cnt3", 32'(cnt_a[3]), 32'd1);
        resetDut();

        // Backpressure on output 2, then delivery and accept in one cycle
        applyStimulus(MODE_ADDR, 1'b1, 8'h5A, 2'd2, 4'b1011);
        applyStimulus(MODE_ADDR, 1'b1, 8'h77, 2'd1, 4'b1011);
        checkOutput("bp_out_data", 32'(bus_a.out_data), 32'h5A);
        applyStimulus(MODE_ADDR, 1'b1, 8'h77, 2'd1, 4'b1011);
        applyStimulus(MODE_ADDR, 1'b1, 8'h77, 2'd1, 4'b1111);
        checkOutput("bp_new_data", 32'(bus_a.out_data), 32'h77);
        applyStimulus(MODE_ADDR, 1'b0, 8'h00, 2'd0, 4'b1111);
        checkOutput("bp_cnt2", 32'(cnt_a[2]), 32'd1);
        checkOutput("bp_cnt1", 32'(cnt_a[1]), 32'd1);
        resetDut();

        // Watchdog drop, then a delivery in the would-be timeout cycle
        applyStimulus(MODE_ADDR, 1'b1, 8'hC3, 2'd3, 4'b0000);
        for (int i = 0; i < TMO; i++)
            applyStimulus(MODE_ADDR, 1'b0, 8'h00, 2'd0, 4'b0000);
        checkOutput("tmo_drop_cnt", 32'(drop_cnt_a), 32'd1);
        checkOutput("tmo_idle", 32'(bus_a.out_valid), 32'h0);
        applyStimulus(MODE_ADDR, 1'b1, 8'hC4, 2'd3, 4'b0000);
        for (int i = 0; i < TMO - 1; i++)
            applyStimulus(MODE_ADDR, 1'b0, 8'h00, 2'd0, 4'b0000);
        applyStimulus(MODE_ADDR, 1'b0, 8'h00, 2'd0, 4'b1000);
        checkOutput("tmo_race_drop_cnt", 32'(drop_cnt_a), 32'd1);
        checkOutput("tmo_race_cnt3", 32'(cnt_a[3]), 32'd1);
        resetDut();

        // Saturation of the 2-bit counters
        for (int i = 0; i < 5; i++)
            applyStimulus(MODE_ADDR, 1'b1, 8'(i), 2'd1, 4'b1111);
        applyStimulus(MODE_ADDR, 1'b0, 8'h00, 2'd0, 4'b1111);
        applyStimulus(MODE_ADDR, 1'b0, 8'h00, 2'd0, 4'b1111);
        checkOutput("sat_cnt1_b", 32'(cnt_b[1]), 32'd3);
        checkOutput("sat_cnt1_a", 32'(cnt_a[1]), 32'd5);
        resetDut();

        // Randomized traffic with mode switches, stalls and a mid-run reset
        md       = MODE_ADDR;
        rdy_mask = 4'b1111;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) md = 1'($urandom);
            if ($urandom_range(0, 31) == 0) rdy_mask = 4'($urandom);
            applyStimulus(md, 1'($urandom_range(0, 9) < 7), 8'($urandom), 2'($urandom),
                          4'($urandom) & rdy_mask);
            if (i == 400) resetDut();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
